disp_scan_ctrl: RTL

Time-multiplexing controller for the board's multi-digit seven-segment display. Holds a short message of 5-bit character codes, scans it across the digits one at a time, and optionally scrolls messages longer than the display. Sits between the character source (terminal/keyboard logic) and the 5-bit seven-segment character decoder: it drives the decoder's code input and the digit anodes.

---
 rtl/disp_pkg.sv | 18 +
 rtl/disp_slot_timer.sv | 39 +++
 rtl/disp_scan_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// disp_pkg: shared types and constants for the seven-segment scan controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package disp_pkg;

  // Decoder code that lights no segments.
  localparam logic [4:0] CHAR_BLANK = 5'h1F;

  // 5-bit character code as understood by the segment decoder.
  typedef logic [4:0] char_t;

  // Scan FSM: a short all-anodes-off guard, then the digit is driven.
  typedef enum logic {
    S_GUARD = 1'b0,
    S_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/disp_slot_timer.sv
// disp_slot_timer: free-running slot-cycle counter for the display scan.
// Latency: strobes are combinational decodes of the registered count.
// Backpressure: none; counts every cycle out of reset.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   guard_done  - high on the last guard cycle of a slot
//   slot_done   - high on the last cycle of a slot
module disp_slot_timer #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic guard_done,
  output logic slot_done
);

  localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD_CYCLES - 1);

  logic [CNT_W-1:0] slot_cnt;

  // Counter restarts at 0 on every slot boundary, so slot length is exact.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt <= '0;
    end else if (slot_cnt == LAST_CNT) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  assign guard_done = (slot_cnt == GUARD_CNT);
  assign slot_done  = (slot_cnt == LAST_CNT);

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: message buffer + time-multiplexed digit scan with optional scrolling.
// Latency: write visible in buf_count after 1 cycle; on display at the next guard entry of its digit.
// Backpressure: wr_ready drops while full, while clear is pulsed, and during reset.
//
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   wr_valid/wr_ready    - append handshake for wr_char
//   wr_char              - 5-bit character code to append
//   clear                - one-cycle pulse, empties the message (wins over a write)
//   scroll_en            - allow scrolling when the message is longer than the display
//   char_code            - registered code for the decoder, stable for a whole slot
//   an_n                 - registered active-low digit select, at most one bit low
//   buf_count, full      - fill level of the message buffer
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int BUF_DEPTH     = 16,
  parameter int SLOT_CYCLES   = 100000,
  parameter int GUARD_CYCLES  = 2,
  parameter int SCROLL_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4:0]            wr_char,
  input  logic                  clear,
  input  logic                  scroll_en,
  output logic [4:0]            char_code,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [4:0]            buf_count,
  output logic                  full
);

  localparam int DIGIT_W = $clog2(NUM_DIGITS);
  localparam int FRAME_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [4:0]         ND5        = 5'(NUM_DIGITS);
  localparam logic [4:0]         DEPTH5     = 5'(BUF_DEPTH);
  localparam logic [DIGIT_W-1:0] LAST_DIGIT = DIGIT_W'(NUM_DIGITS - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(SCROLL_FRAMES - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  char_t                buf_mem [BUF_DEPTH];
  scan_state_t          state, state_nxt;
  logic [DIGIT_W-1:0]   digit, digit_nxt;
  logic [FRAME_W-1:0]   frame_cnt, frame_nxt;
  logic [3:0]           base, base_nxt;
  logic [NUM_DIGITS-1:0] an_n_nxt;
  logic [NUM_DIGITS-1:0] digit_onehot;

  logic guard_done;
  logic slot_done;
  logic advance;       // S_DRIVE -> S_GUARD: next digit's guard entry
  logic wrap;          // advance out of the last digit: frame boundary
  logic wr_fire;
  logic scroll_active;

  char_t      sel_char;
  logic [4:0] sel_idx;
  logic [4:0] digit_ext;

  disp_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .GUARD_CYCLES (GUARD_CYCLES)
  ) u_slot_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .guard_done (guard_done),
    .slot_done  (slot_done)
  );

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  assign full     = (buf_count == DEPTH5);
  assign wr_ready = rst_n & ~full & ~clear;
  assign wr_fire  = wr_valid & wr_ready;

  // Contents need no reset: buf_count gates everything that reads them.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      buf_mem[buf_count[3:0]] <= wr_char;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_count <= 5'd0;
    end else if (clear) begin
      buf_count <= 5'd0;
    end else if (wr_fire) begin
      buf_count <= buf_count + 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    digit_onehot        = '0;
    digit_onehot[digit] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    an_n_nxt  = an_n;
    advance   = 1'b0;
    case (state)
      S_GUARD: begin
        if (guard_done) begin
          state_nxt = S_DRIVE;
          an_n_nxt  = ~digit_onehot;
        end
      end
      S_DRIVE: begin
        if (slot_done) begin
          state_nxt = S_GUARD;
          an_n_nxt  = '1;
          advance   = 1'b1;
        end
      end
      default: begin
        state_nxt = S_GUARD;
        an_n_nxt  = '1;
      end
    endcase
  end

  assign wrap      = advance & (digit == LAST_DIGIT);
  assign digit_nxt = advance ? (wrap ? '0 : digit + 1'b1) : digit;

  // ---------------------------------------------------------------------------
  // Scroll window. base only moves on a frame wrap, and the same-edge char
  // selection below uses base_nxt, so digit 0 of the new frame already sees
  // the new window and no frame mixes two positions.
  // ---------------------------------------------------------------------------
  assign scroll_active = scroll_en & (buf_count > ND5);

  always_comb begin
    base_nxt  = base;
    frame_nxt = frame_cnt;
    if (clear) begin
      base_nxt  = 4'd0;
      frame_nxt = '0;
    end else if (!scroll_active) begin
      frame_nxt = '0;
    end else if (wrap) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_nxt = '0;
        base_nxt  = (({1'b0, base} + 5'd1) == buf_count) ? 4'd0 : base + 4'd1;
      end else begin
        frame_nxt = frame_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Character selection for the digit about to be shown. The sum base+digit
  // stays below 2*buf_count, so one conditional subtract is enough.
  // ---------------------------------------------------------------------------
  assign digit_ext = {{(5 - DIGIT_W){1'b0}}, digit_nxt};

  always_comb begin
    sel_char = CHAR_BLANK;
    sel_idx  = 5'd0;
    if (buf_count <= ND5) begin
      if (digit_ext < buf_count) begin
        sel_char = buf_mem[digit_ext[3:0]];
      end
    end else begin
      sel_idx = {1'b0, base_nxt} + digit_ext;
      if (sel_idx >= buf_count) begin
        sel_idx = sel_idx - buf_count;
      end
      sel_char = buf_mem[sel_idx[3:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_GUARD;
      digit     <= '0;
      frame_cnt <= '0;
      base      <= 4'd0;
      an_n      <= '1;
      char_code <= CHAR_BLANK;
    end else begin
      state     <= state_nxt;
      digit     <= digit_nxt;
      frame_cnt <= frame_nxt;
      base      <= base_nxt;
      an_n      <= an_n_nxt;
      if (advance) begin
        char_code <= sel_char;
      end
    end
  end

endmodule
